// File: rtl/tx_req_queue_if.sv
// Memory-mapped register bus between software master and single-cycle peripherals.
// The peripheral_vital modport is the slave view used by tx_req_queue.
interface bus_protocol_if;
    logic [31:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;

    modport master (
        output addr, wen, ren, wdata,
        input  rdata, error, request_stall
    );

    modport peripheral_vital (
        input  addr, wen, ren, wdata,
        output rdata, error, request_stall
    );
endinterface

// File: rtl/tx_req_queue.sv
// Transmit request queue: software pushes {dest,len} through bus writes, packet builder pops
// via valid/ready. Optional drain interrupt register enabled by macro TX_REQ_IRQ_EN.
module tx_req_queue #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    bus_protocol_if.peripheral_vital bus_if,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [4:0]              req_dest,
    output logic [7:0]              req_len,
    output logic                    overrun,
    output logic                    irq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [31:0] ADDR_PUSH   = 32'h0000_3500;
    localparam logic [31:0] ADDR_COUNT  = 32'h0000_3504;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_3508;
    localparam logic [31:0] ADDR_CLEAR  = 32'h0000_350C;
    localparam logic [31:0] ADDR_SENT   = 32'h0000_3510;
    localparam logic [31:0] ADDR_IRQ    = 32'h0000_3514;

    logic [12:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             over_q, over_d;
    logic [15:0]      sent_q, sent_d;

    logic push_s, push_ok_s, pop_s, clear_s, sent_wr_s, full_s, empty_s;
    logic [12:0] head_entry_s;

    assign full_s    = (count_q == FULL_CNT);
    assign empty_s   = (count_q == '0);
    assign push_s    = bus_if.wen && (bus_if.addr == ADDR_PUSH);
    assign clear_s   = bus_if.wen && (bus_if.addr == ADDR_CLEAR);
    assign sent_wr_s = bus_if.wen && (bus_if.addr == ADDR_SENT);
    assign push_ok_s = push_s && !full_s && !clear_s;
    assign pop_s     = !empty_s && req_ready && !clear_s;

    // Next-state for pointers, occupancy, overrun flag and sent counter; CLEAR overrides push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        over_d  = over_q;
        sent_d  = sent_q;
        if (clear_s) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            over_d  = 1'b0;
        end else begin
            if (pop_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            if (push_ok_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (push_s && full_s) begin
                over_d = 1'b1;
            end else begin
                over_d = over_q;
            end
            count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_s);
        end
        if (sent_wr_s) begin
            sent_d = 16'd0;
        end else if (pop_s) begin
            sent_d = sent_q + 16'd1;
        end else begin
            sent_d = sent_q;
        end
    end

    // Queue control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            over_q  <= 1'b0;
            sent_q  <= 16'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            over_q  <= over_d;
            sent_q  <= sent_d;
        end
    end

    // Entry storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !rst) begin
            mem_q[tail_q] <= {bus_if.wdata[4:0], bus_if.wdata[15:8]};
        end
    end

    assign head_entry_s = empty_s ? 13'd0 : mem_q[head_q];
    assign req_valid    = !empty_s;
    assign req_dest     = head_entry_s[12:8];
    assign req_len      = head_entry_s[7:0];
    assign overrun      = over_q;

`ifdef TX_REQ_IRQ_EN
    logic irq_en_q, irq_en_d, drain_q, drain_d, irq_q;
    logic irq_wr_s, drain_set_s;

    // Drain event: a pop that leaves the queue empty (push in the same cycle keeps it non-empty).
    assign irq_wr_s    = bus_if.wen && (bus_if.addr == ADDR_IRQ);
    assign drain_set_s = pop_s && !push_ok_s && (count_q == CNT_W'(1));

    // IRQ register next-state; a new drain event beats a write-1-clear.
    always_comb begin
        irq_en_d = irq_en_q;
        drain_d  = drain_q;
        if (irq_wr_s) begin
            irq_en_d = bus_if.wdata[0];
        end else begin
            irq_en_d = irq_en_q;
        end
        if (drain_set_s) begin
            drain_d = 1'b1;
        end else if (irq_wr_s && bus_if.wdata[1]) begin
            drain_d = 1'b0;
        end else begin
            drain_d = drain_q;
        end
    end

    // IRQ flops; irq is registered from the next-state so it tracks the flag without extra lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            drain_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            drain_q  <= drain_d;
            irq_q    <= irq_en_d && drain_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Combinational read mux.
    always_comb begin
        bus_if.rdata = 32'd0;
        if (bus_if.ren) begin
            case (bus_if.addr)
                ADDR_COUNT:  bus_if.rdata = 32'(count_q);
                ADDR_STATUS: bus_if.rdata = {29'd0, over_q, full_s, empty_s};
                ADDR_SENT:   bus_if.rdata = {16'd0, sent_q};
`ifdef TX_REQ_IRQ_EN
                ADDR_IRQ:    bus_if.rdata = {30'd0, drain_q, irq_en_q};
`endif
                default:     bus_if.rdata = 32'd0;
            endcase
        end else begin
            bus_if.rdata = 32'd0;
        end
    end

    assign bus_if.error         = 1'b0;
    assign bus_if.request_stall = 1'b0;
endmodule

// File: tb/tb_tx_req_queue.sv
// Directed bench for tx_req_queue with a scoreboard queue of expected head entries.
// Define TX_REQ_IRQ_EN to also exercise the drain interrupt register.
module tb_tx_req_queue;
    localparam logic [31:0] A_PUSH   = 32'h3500;
    localparam logic [31:0] A_COUNT  = 32'h3504;
    localparam logic [31:0] A_STATUS = 32'h3508;
    localparam logic [31:0] A_CLEAR  = 32'h350C;
    localparam logic [31:0] A_SENT   = 32'h3510;
    localparam logic [31:0] A_IRQ    = 32'h3514;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid, req_ready, overrun, irq;
    logic [4:0] req_dest;
    logic [7:0] req_len;

    bus_protocol_if bus ();

    tx_req_queue dut (
        .clk       (clk),
        .rst       (rst),
        .bus_if    (bus),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dest  (req_dest),
        .req_len   (req_len),
        .overrun   (overrun),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [12:0] sb[$];
    logic        m_over = 1'b0;
    logic [15:0] m_sent = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.wen = 1'b0; bus.ren = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0; req_ready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.ren = 1'b1; bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.wen = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        idle();
    endtask

    // One cycle of push/pop/clear, checking head against the scoreboard before the edge.
    task automatic step(input bit do_push, input logic [4:0] d, input logic [7:0] l,
                        input bit do_pop, input bit do_clear, input string tag);
        logic [12:0] head;
        bit was_full;
        chk({tag, ":valid"}, 32'(req_valid), 32'(sb.size() != 0));
        chk({tag, ":overrun"}, 32'(overrun), 32'(m_over));
`ifndef TX_REQ_IRQ_EN
        chk({tag, ":irq"}, 32'(irq), 32'd0);
`endif
        if (sb.size() != 0) begin
            head = sb[0];
            chk({tag, ":dest"}, 32'(req_dest), 32'(head[12:8]));
            chk({tag, ":len"}, 32'(req_len), 32'(head[7:0]));
        end
        if (do_clear) begin
            bus.wen = 1'b1; bus.addr = A_CLEAR; bus.wdata = 32'd0;
        end else if (do_push) begin
            bus.wen = 1'b1; bus.addr = A_PUSH; bus.wdata = {16'd0, l, 3'd0, d};
        end
        req_ready = do_pop;
        @(posedge clk);
        if (do_clear) begin
            sb.delete();
            m_over = 1'b0;
        end else begin
            was_full = (sb.size() == 16);
            if (do_pop && sb.size() != 0) begin
                void'(sb.pop_front());
                m_sent = m_sent + 16'd1;
            end
            if (do_push) begin
                if (was_full) m_over = 1'b1;
                else sb.push_back({d, l});
            end
        end
        #1;
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // Reset state
        chk("rst:valid", 32'(req_valid), 32'd0);
        chk("rst:overrun", 32'(overrun), 32'd0);
        chk("rst:irq", 32'(irq), 32'd0);
        chk("rst:dest", 32'(req_dest), 32'd0);
        chk("rst:len", 32'(req_len), 32'd0);
        chk("rst:err", 32'({bus.error, bus.request_stall}), 32'd0);
        chk("rst:rdata_idle", bus.rdata, 32'd0);
        rd(A_COUNT, 32'd0, "rst:count");
        rd(A_STATUS, 32'h1, "rst:status");
        rd(A_SENT, 32'd0, "rst:sent");
        rd(A_PUSH, 32'd0, "rd:push");
        rd(32'h3518, 32'd0, "rd:unlisted");
`ifndef TX_REQ_IRQ_EN
        rd(A_IRQ, 32'd0, "rd:irq_absent");
`endif

        // Basic push then drain
        step(1'b1, 5'd5, 8'd8, 1'b0, 1'b0, "b:push1");
        step(1'b1, 5'h1F, 8'hFF, 1'b0, 1'b0, "b:push2");
        rd(A_COUNT, 32'd2, "b:count2");
        step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0, "b:pop1");
        step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0, "b:pop2");
        step(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, "b:idle");
        rd(A_COUNT, 32'd0, "b:count0");
        rd(A_SENT, 32'd2, "b:sent2");
        rd(A_STATUS, 32'h1, "b:status");

        // Push into empty queue with ready high: no pop that cycle
        step(1'b1, 5'd9, 8'h33, 1'b1, 1'b0, "e:push_ready");
        step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0, "e:pop");

        // Fill, overflow, push+pop while full, clear
        for (int i = 0; i < 17; i++)
            step(1'b1, 5'(i), 8'(i * 3 + 1), 1'b0, 1'b0, "f:push");
        rd(A_COUNT, 32'd16, "f:count16");
        rd(A_STATUS, 32'h6, "f:status");
        chk("f:overrun", 32'(overrun), 32'd1);
        step(1'b1, 5'd7, 8'd7, 1'b1, 1'b0, "f:pushpop_full");
        rd(A_COUNT, 32'd15, "f:count15");
        step(1'b0, 5'd0, 8'd0, 1'b0, 1'b1, "f:clear");
        rd(A_COUNT, 32'd0, "f:count_clr");
        rd(A_STATUS, 32'h1, "f:status_clr");

        // Wrap with count held at 3
        wr(A_SENT, 32'd1);
        m_sent = 16'd0;
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'(i), 8'(i + 8'h40), 1'b0, 1'b0, "w:pre");
        for (int i = 3; i < 40; i++)
            step(1'b1, 5'(i), 8'(i + 8'h40), 1'b1, 1'b0, "w:pushpop");
        for (int i = 0; i < 3; i++)
            step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0, "w:drain");
        rd(A_SENT, 32'd40, "w:sent40");

        // Sent counter wrap at 16 bits
        wr(A_SENT, 32'd0);
        m_sent = 16'd0;
        step(1'b1, 5'h0A, 8'h11, 1'b0, 1'b0, "s:seed");
        bus.wen = 1'b1; bus.addr = A_PUSH; bus.wdata = {16'd0, 8'h11, 3'd0, 5'h0A}; req_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        idle();
        m_sent = 16'hFFFF;
        rd(A_SENT, 32'hFFFF, "s:sent_ffff");
        rd(A_COUNT, 32'd1, "s:count1");
        step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0, "s:last_pop");
        rd(A_SENT, 32'd0, "s:sent_wrap");

        // CLEAR coincident with pop of a 4-entry queue
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(i + 20), 8'(i + 8'h90), 1'b0, 1'b0, "c:push");
        step(1'b0, 5'd0, 8'd0, 1'b1, 1'b1, "c:clear_pop");
        step(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, "c:after");
        rd(A_COUNT, 32'd0, "c:count");
        rd(A_SENT, 32'(m_sent), "c:sent_same");

`ifdef TX_REQ_IRQ_EN
        // Drain interrupt
        wr(A_IRQ, 32'h1);
        rd(A_IRQ, 32'h1, "i:en");
        step(1'b1, 5'd3, 8'd3, 1'b0, 1'b0, "i:push");
        step(1'b0, 5'd0, 8'd0, 1'b1, 1'b0, "i:pop");
        chk("i:irq_set", 32'(irq), 32'd1);
        wr(A_IRQ, 32'h2);
        chk("i:irq_clr", 32'(irq), 32'd0);
        wr(A_IRQ, 32'h1);
        step(1'b1, 5'd4, 8'd4, 1'b0, 1'b0, "i:push2");
        step(1'b0, 5'd0, 8'd0, 1'b0, 1'b1, "i:clear");
        chk("i:irq_noclr", 32'(irq), 32'd0);
        rd(A_IRQ, 32'h1, "i:reg");
`endif

        // Reset in the middle of a transfer
        step(1'b1, 5'd1, 8'd2, 1'b0, 1'b0, "r:push");
        req_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        sb.delete(); m_over = 1'b0; m_sent = 16'd0;
        chk("r:valid", 32'(req_valid), 32'd0);
        rd(A_COUNT, 32'd0, "r:count");
        rd(A_SENT, 32'd0, "r:sent");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
